usb_rx_packet_deserializer: RTL and testbench
=============================================

# usb_rx_packet_deserializer

Host-side receive front end of the USB hub. Samples the differential receive pair (`host_rx_plus`/`host_rx_minus`) once per recovered bit, detects SYNC, performs NRZI decoding and bit unstuffing, assembles LSB-first bytes, and detects EOP. It feeds the hub's packet decoder with a byte stream plus packet-boundary and error strobes. The bit-timing recovery block upstream supplies the per-bit sample strobe.

## Interface

Parameters:
- `SYNC_KJ_PAIRS`, default 3: number of KJ pairs required before the closing KK of SYNC (full-speed SYNC = KJKJKJKK).

Ports:
- `hi_clock`  input  1  sole clock; all state changes on its rising edge.
- `reset`  input  1  asynchronous, active-high reset.
- `bit_strobe`  input  1  one-cycle pulse marking a bit-centre sample; logic advances only on cycles with `bit_strobe`=1.
- `rx_plus`  input  1  D+ receive line.
- `rx_minus`  input  1  D- receive line.
- `rx_active`  output  1  high from SYNC completion until EOP or error.
- `rx_data`  output  8  assembled byte; valid only with `rx_valid`.
- `rx_valid`  output  1  one-cycle pulse, one per received byte.
- `rx_eop`  output  1  one-cycle pulse on clean end of packet.
- `rx_error`  output  1  one-cycle pulse on stuff error, SE1, partial byte at EOP, or bad EOP.
- `rx_state`  output  4  debug: current FSM state encoding.

## Operation

- Line decode per strobe: J=(1,0), K=(0,1), SE0=(0,0), SE1=(1,1).
- FSM states (encoding on `rx_state`): IDLE=0, SYNC=1, DATA=2, EOP=3, ABORT=4.
- IDLE: waits for K after J; K moves to SYNC with KJ pair count=0. SE0/SE1/J stay in IDLE. No outputs pulse.
- SYNC: expects alternating K/J; each completed KJ increments pair count. After `SYNC_KJ_PAIRS` pairs, a K following K (KK) completes SYNC: go DATA, `rx_active`<=1, ones counter<=1, bit counter<=0. Any other violation (JJ, KK too early, SE0) returns to IDLE silently; SE1 also returns to IDLE silently (no packet was started).
- DATA, per strobe with J or K:
  - NRZI: bit=1 if line equals previous line state, bit=0 if different. Previous line state updates every strobe.
  - Unstuffing: count consecutive 1s (saturating at 6). When count=6 the next bit must be 0 and is discarded (not shifted, counter->0). If that bit is 1: `rx_error` pulse, `rx_active`<=0, go ABORT.
  - Data bits shift in LSB first; on 8th bit `rx_data`<=byte, `rx_valid` pulse, bit counter wraps to 0.
  - SE0: if bit counter=0 go EOP; else `rx_error` pulse, `rx_active`<=0, go ABORT.
  - SE1: `rx_error` pulse, `rx_active`<=0, go ABORT.
- EOP: accepts one additional SE0 (max two total). Then J: `rx_eop` pulse, `rx_active`<=0, go IDLE. K, SE1, or third SE0: `rx_error` pulse, `rx_active`<=0, go ABORT.
- ABORT: waits for J, then IDLE. No pulses.
- `rx_valid`, `rx_eop`, `rx_error` are mutually exclusive in any cycle; never two in the same cycle.

## Timing

- Reset values: `rx_active`=0, `rx_data`=8'h00, `rx_valid`=0, `rx_eop`=0, `rx_error`=0, `rx_state`=IDLE; previous line state=J; all counters 0.
- Reset mid-packet: immediate return to reset values; no `rx_eop` or `rx_error` emitted.
- All outputs are registered. Pulses assert the `hi_clock` cycle after the edge that samples the triggering strobe, and last exactly one cycle even if `bit_strobe` is held high.
- `rx_active` rises the cycle after the strobe sampling the closing K of SYNC, and falls together with `rx_eop` or `rx_error`.
- `rx_data` holds its last value between `rx_valid` pulses.
- Back-to-back strobes (every cycle) are legal and must be handled at full rate.
- A stuffed bit after the final data bit, immediately before SE0, is consumed normally and does not count as a partial byte.

## Test plan

- Clean packet: SYNC, then byte 8'hA5, then SE0, SE0, J -> `rx_active` high, one `rx_valid` with `rx_data`=8'hA5, one `rx_eop`, no `rx_error`, `rx_state` back to 0.
- Stuffing: bytes 8'hFF, 8'hFF with stuffed zeros inserted after every six 1s -> two `rx_valid` pulses carrying 8'hFF each, then `rx_eop`; the stuffed bits are not visible in the data.
- Stuff error: send seven consecutive 1s in DATA -> `rx_error` pulse on the 7th bit, `rx_active` falls the same cycle, state 4, then IDLE after J.
- Partial byte: SYNC, 5 data bits, SE0 -> `rx_error`, no `rx_valid`, no `rx_eop`.
- Broken SYNC: KJKJJ -> return to IDLE, `rx_active` never asserted, no pulses; a following valid SYNC plus byte 8'h3C is received correctly.
- Reset mid-byte after 3 bits of 8'h5A -> all outputs 0 immediately; a subsequent full packet with 8'h5A yields exactly one `rx_valid` pulse with 8'h5A.

Source files
------------

// File: rtl/usb_rx_packet_deserializer_if.sv
// Receive-side bundle between the bit-timing recovery block, the line pair and
// the packet decoder. The master drives strobe and line; the slave drives the byte stream.
interface usb_rx_packet_deserializer_if;
    logic       bit_strobe;
    logic       rx_plus;
    logic       rx_minus;
    logic       rx_active;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_eop;
    logic       rx_error;
    logic [3:0] rx_state;

    modport master (
        output bit_strobe, rx_plus, rx_minus,
        input  rx_active, rx_data, rx_valid, rx_eop, rx_error, rx_state
    );

    modport slave (
        input  bit_strobe, rx_plus, rx_minus,
        output rx_active, rx_data, rx_valid, rx_eop, rx_error, rx_state
    );
endinterface

// File: rtl/usb_rx_packet_deserializer.sv
// USB receive front end: SYNC detect, NRZI decode, bit unstuffing, LSB-first
// byte assembly and EOP detection, advancing only on bit-centre strobes.
module usb_rx_packet_deserializer #(
    parameter int SYNC_KJ_PAIRS = 3
) (
    input  logic                          hi_clock,
    input  logic                          reset,
    usb_rx_packet_deserializer_if.slave   bus
);
    typedef enum logic [3:0] {
        ST_IDLE  = 4'd0,
        ST_SYNC  = 4'd1,
        ST_DATA  = 4'd2,
        ST_EOP   = 4'd3,
        ST_ABORT = 4'd4
    } state_t;

    localparam int PW = $clog2(SYNC_KJ_PAIRS + 1) + 1;
    localparam logic [PW-1:0] PAIRS_NEEDED = PW'(SYNC_KJ_PAIRS);
    localparam logic [1:0] LINE_SE0 = 2'b00;
    localparam logic [1:0] LINE_K   = 2'b01;
    localparam logic [1:0] LINE_J   = 2'b10;

    state_t        state_r, state_s;
    logic [1:0]    prev_line_r, prev_line_s;
    logic [PW-1:0] pair_cnt_r, pair_cnt_s;
    logic [2:0]    ones_cnt_r, ones_cnt_s;
    logic [2:0]    bit_cnt_r, bit_cnt_s;
    logic [7:0]    shift_r, shift_s;
    logic [7:0]    data_r, data_s;
    logic          se0_two_r, se0_two_s;
    logic          active_r, active_s;
    logic          valid_r, valid_s;
    logic          eop_r, eop_s;
    logic          error_r, error_s;
    logic [1:0]    line_s;
    logic          nrzi_bit_s;

    assign line_s     = {bus.rx_plus, bus.rx_minus};
    assign nrzi_bit_s = (line_s == prev_line_r);

    // Next-state, datapath and pulse generation for one bit strobe
    always_comb begin
        state_s     = state_r;
        prev_line_s = prev_line_r;
        pair_cnt_s  = pair_cnt_r;
        ones_cnt_s  = ones_cnt_r;
        bit_cnt_s   = bit_cnt_r;
        shift_s     = shift_r;
        data_s      = data_r;
        se0_two_s   = se0_two_r;
        active_s    = active_r;
        valid_s     = 1'b0;
        eop_s       = 1'b0;
        error_s     = 1'b0;
        if (bus.bit_strobe) begin
            // Only J/K carry a line level for NRZI; SE0/SE1 leave the reference alone
            if ((line_s == LINE_J) || (line_s == LINE_K)) begin
                prev_line_s = line_s;
            end else begin
                prev_line_s = prev_line_r;
            end
            case (state_r)
                ST_IDLE: begin
                    if ((line_s == LINE_K) && (prev_line_r == LINE_J)) begin
                        state_s    = ST_SYNC;
                        pair_cnt_s = {PW{1'b0}};
                    end else begin
                        state_s = ST_IDLE;
                    end
                end
                ST_SYNC: begin
                    case (line_s)
                        LINE_J: begin
                            if (prev_line_r == LINE_K) begin
                                if (pair_cnt_r < PAIRS_NEEDED) begin
                                    pair_cnt_s = pair_cnt_r + PW'(1);
                                end else begin
                                    pair_cnt_s = pair_cnt_r;
                                end
                            end else begin
                                state_s = ST_IDLE;
                            end
                        end
                        LINE_K: begin
                            if (prev_line_r == LINE_J) begin
                                state_s = ST_SYNC;
                            end else if (pair_cnt_r >= PAIRS_NEEDED) begin
                                state_s    = ST_DATA;
                                active_s   = 1'b1;
                                ones_cnt_s = 3'd1;
                                bit_cnt_s  = 3'd0;
                            end else begin
                                state_s = ST_IDLE;
                            end
                        end
                        default: state_s = ST_IDLE;
                    endcase
                end
                ST_DATA: begin
                    case (line_s)
                        LINE_J, LINE_K: begin
                            if (ones_cnt_r == 3'd6) begin
                                // Stuffed slot: must be a zero and is dropped
                                if (nrzi_bit_s) begin
                                    error_s  = 1'b1;
                                    active_s = 1'b0;
                                    state_s  = ST_ABORT;
                                end else begin
                                    ones_cnt_s = 3'd0;
                                end
                            end else begin
                                if (nrzi_bit_s) begin
                                    ones_cnt_s = ones_cnt_r + 3'd1;
                                end else begin
                                    ones_cnt_s = 3'd0;
                                end
                                shift_s   = {nrzi_bit_s, shift_r[7:1]};
                                bit_cnt_s = bit_cnt_r + 3'd1;
                                if (bit_cnt_r == 3'd7) begin
                                    data_s  = shift_s;
                                    valid_s = 1'b1;
                                end else begin
                                    data_s = data_r;
                                end
                            end
                        end
                        LINE_SE0: begin
                            if (bit_cnt_r == 3'd0) begin
                                state_s   = ST_EOP;
                                se0_two_s = 1'b0;
                            end else begin
                                error_s  = 1'b1;
                                active_s = 1'b0;
                                state_s  = ST_ABORT;
                            end
                        end
                        default: begin
                            error_s  = 1'b1;
                            active_s = 1'b0;
                            state_s  = ST_ABORT;
                        end
                    endcase
                end
                ST_EOP: begin
                    if (line_s == LINE_J) begin
                        eop_s    = 1'b1;
                        active_s = 1'b0;
                        state_s  = ST_IDLE;
                    end else if ((line_s == LINE_SE0) && !se0_two_r) begin
                        se0_two_s = 1'b1;
                    end else begin
                        error_s  = 1'b1;
                        active_s = 1'b0;
                        state_s  = ST_ABORT;
                    end
                end
                ST_ABORT: begin
                    if (line_s == LINE_J) begin
                        state_s = ST_IDLE;
                    end else begin
                        state_s = ST_ABORT;
                    end
                end
                default: begin
                    active_s = 1'b0;
                    state_s  = ST_IDLE;
                end
            endcase
        end else begin
            state_s = state_r;
        end
    end

    // State and output registers
    always_ff @(posedge hi_clock or posedge reset) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            prev_line_r <= LINE_J;
            pair_cnt_r  <= {PW{1'b0}};
            ones_cnt_r  <= 3'd0;
            bit_cnt_r   <= 3'd0;
            shift_r     <= 8'h00;
            data_r      <= 8'h00;
            se0_two_r   <= 1'b0;
            active_r    <= 1'b0;
            valid_r     <= 1'b0;
            eop_r       <= 1'b0;
            error_r     <= 1'b0;
        end else begin
            state_r     <= state_s;
            prev_line_r <= prev_line_s;
            pair_cnt_r  <= pair_cnt_s;
            ones_cnt_r  <= ones_cnt_s;
            bit_cnt_r   <= bit_cnt_s;
            shift_r     <= shift_s;
            data_r      <= data_s;
            se0_two_r   <= se0_two_s;
            active_r    <= active_s;
            valid_r     <= valid_s;
            eop_r       <= eop_s;
            error_r     <= error_s;
        end
    end

    assign bus.rx_active = active_r;
    assign bus.rx_data   = data_r;
    assign bus.rx_valid  = valid_r;
    assign bus.rx_eop    = eop_r;
    assign bus.rx_error  = error_r;
    assign bus.rx_state  = state_r;
endmodule

// File: tb/tb_usb_rx_packet_deserializer.sv
// Directed bench for usb_rx_packet_deserializer: line symbols are built by a
// small NRZI/stuffing encoder and results are compared against hand-computed values.
module tb_usb_rx_packet_deserializer;
    localparam logic [1:0] J   = 2'b10;
    localparam logic [1:0] K   = 2'b01;
    localparam logic [1:0] SE0 = 2'b00;

    logic hi_clock = 1'b0;
    logic reset;
    always #5 hi_clock = ~hi_clock;

    usb_rx_packet_deserializer_if bus();

    usb_rx_packet_deserializer #(.SYNC_KJ_PAIRS(3)) dut (
        .hi_clock (hi_clock),
        .reset    (reset),
        .bus      (bus)
    );

    int         n_tests = 0;
    int         n_fail  = 0;
    int         n_valid, n_eop, n_error, n_multi, n_err_act;
    logic       seen_active;
    logic [7:0] got_q[$];
    logic [1:0] tb_line;
    int         ones;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Pulse monitor, sampled away from the active edge
    always @(negedge hi_clock) begin
        if (!reset) begin
            if (bus.rx_valid) begin
                n_valid++;
                got_q.push_back(bus.rx_data);
            end
            if (bus.rx_eop) n_eop++;
            if (bus.rx_error) n_error++;
            if (bus.rx_error && bus.rx_active) n_err_act++;
            if ((32'(bus.rx_valid) + 32'(bus.rx_eop) + 32'(bus.rx_error)) > 32'd1) n_multi++;
            if (bus.rx_active) seen_active = 1'b1;
        end
    end

    task automatic clear_counts();
        n_valid = 0; n_eop = 0; n_error = 0; seen_active = 1'b0;
        got_q.delete();
    endtask

    task automatic sym(input logic [1:0] s);
        @(negedge hi_clock);
        bus.rx_plus    = s[1];
        bus.rx_minus   = s[0];
        bus.bit_strobe = 1'b1;
        if ((s == J) || (s == K)) tb_line = s;
    endtask

    task automatic gap(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge hi_clock);
            bus.bit_strobe = 1'b0;
        end
    endtask

    task automatic raw_bit(input logic b);
        logic [1:0] nxt;
        nxt = b ? tb_line : ~tb_line;
        sym(nxt);
    endtask

    task automatic data_bit(input logic b);
        raw_bit(b);
        if (b) ones++; else ones = 0;
        if (ones == 6) begin
            raw_bit(1'b0);
            ones = 0;
        end
    endtask

    task automatic send_byte(input logic [7:0] x);
        for (int i = 0; i < 8; i++) data_bit(x[i]);
    endtask

    task automatic send_sync();
        sym(K); sym(J); sym(K); sym(J); sym(K); sym(J); sym(K); sym(K);
        ones = 1;
    endtask

    task automatic send_eop();
        sym(SE0); sym(SE0); sym(J);
    endtask

    initial begin
        reset = 1'b1;
        bus.bit_strobe = 1'b0; bus.rx_plus = 1'b1; bus.rx_minus = 1'b0;
        tb_line = J; ones = 0; n_multi = 0; n_err_act = 0;
        clear_counts();
        repeat (3) @(negedge hi_clock);
        check("rst_state", 32'(bus.rx_state), 32'd0);
        check("rst_active", 32'(bus.rx_active), 32'd0);
        check("rst_data", 32'(bus.rx_data), 32'h00);
        check("rst_pulses", {29'd0, bus.rx_valid, bus.rx_eop, bus.rx_error}, 32'd0);
        reset = 1'b0;
        gap(2);

        // Clean packet A5
        clear_counts();
        send_sync();
        gap(1);
        check("a5_active", 32'(bus.rx_active), 32'd1);
        check("a5_state_data", 32'(bus.rx_state), 32'd2);
        send_byte(8'hA5); send_eop(); gap(3);
        check("a5_nvalid", n_valid, 32'd1);
        check("a5_data", (got_q.size() > 0) ? 32'(got_q[0]) : 32'hDEAD, 32'hA5);
        check("a5_neop", n_eop, 32'd1);
        check("a5_nerr", n_error, 32'd0);
        check("a5_state", 32'(bus.rx_state), 32'd0);
        check("a5_active_end", 32'(bus.rx_active), 32'd0);
        check("a5_hold", 32'(bus.rx_data), 32'hA5);

        // Two 8'hFF bytes with stuffing
        clear_counts();
        send_sync(); send_byte(8'hFF); send_byte(8'hFF); send_eop(); gap(3);
        check("ff_nvalid", n_valid, 32'd2);
        check("ff_d0", (got_q.size() > 0) ? 32'(got_q[0]) : 32'hDEAD, 32'hFF);
        check("ff_d1", (got_q.size() > 1) ? 32'(got_q[1]) : 32'hDEAD, 32'hFF);
        check("ff_neop", n_eop, 32'd1);
        check("ff_nerr", n_error, 32'd0);

        // Stuffed bit right before SE0
        clear_counts();
        send_sync(); send_byte(8'hFC); send_eop(); gap(3);
        check("fc_nvalid", n_valid, 32'd1);
        check("fc_data", (got_q.size() > 0) ? 32'(got_q[0]) : 32'hDEAD, 32'hFC);
        check("fc_neop", n_eop, 32'd1);
        check("fc_nerr", n_error, 32'd0);

        // Stuff error: a zero then seven ones
        clear_counts();
        send_sync();
        raw_bit(1'b0);
        for (int i = 0; i < 7; i++) raw_bit(1'b1);
        gap(2);
        check("stf_nerr", n_error, 32'd1);
        check("stf_nvalid", n_valid, 32'd0);
        check("stf_state", 32'(bus.rx_state), 32'd4);
        check("stf_active", 32'(bus.rx_active), 32'd0);
        sym(J); gap(2);
        check("stf_idle", 32'(bus.rx_state), 32'd0);

        // Partial byte at SE0
        clear_counts();
        send_sync();
        data_bit(1'b1); data_bit(1'b0); data_bit(1'b1); data_bit(1'b0); data_bit(1'b1);
        sym(SE0); gap(2);
        check("part_nerr", n_error, 32'd1);
        check("part_state", 32'(bus.rx_state), 32'd4);
        sym(SE0); sym(J); gap(2);
        check("part_nvalid", n_valid, 32'd0);
        check("part_neop", n_eop, 32'd0);
        check("part_idle", 32'(bus.rx_state), 32'd0);

        // Broken SYNC then a good packet
        clear_counts();
        sym(K); sym(J); sym(K); sym(J); sym(J); gap(2);
        check("brk_state", 32'(bus.rx_state), 32'd0);
        check("brk_active", 32'(seen_active), 32'd0);
        check("brk_pulses", n_valid + n_eop + n_error, 32'd0);
        send_sync(); send_byte(8'h3C); send_eop(); gap(3);
        check("3c_nvalid", n_valid, 32'd1);
        check("3c_data", (got_q.size() > 0) ? 32'(got_q[0]) : 32'hDEAD, 32'h3C);
        check("3c_neop", n_eop, 32'd1);

        // Reset mid-byte
        clear_counts();
        send_sync(); data_bit(1'b0); data_bit(1'b1); data_bit(1'b0);
        gap(1);
        check("mid_active", 32'(bus.rx_active), 32'd1);
        reset = 1'b1;
        #1;
        check("mid_rst_active", 32'(bus.rx_active), 32'd0);
        check("mid_rst_state", 32'(bus.rx_state), 32'd0);
        check("mid_rst_data", 32'(bus.rx_data), 32'h00);
        @(negedge hi_clock);
        reset = 1'b0; tb_line = J;
        gap(2);
        check("mid_no_pulse", n_valid + n_eop + n_error, 32'd0);
        clear_counts();
        send_sync(); send_byte(8'h5A); send_eop(); gap(3);
        check("5a_nvalid", n_valid, 32'd1);
        check("5a_data", (got_q.size() > 0) ? 32'(got_q[0]) : 32'hDEAD, 32'h5A);
        check("5a_neop", n_eop, 32'd1);
        check("5a_nerr", n_error, 32'd0);

        check("excl_pulses", n_multi, 32'd0);
        check("err_active_low", n_err_act, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
